// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - write-only I2C target receiver with address match and byte delivery
//
// Oversamples SCL/SDA on CLK_IN, detects START/STOP, matches a 7-bit address
// (R/W must be 0), ACKs by pulling SDA low and hands each received data byte
// to the fabric. A byte the consumer cannot take is NACKed and dropped.
//
// Optional build macro: I2C_RX_GENCALL_EN - when defined, the address byte
// 8'h00 (general call) is accepted exactly like ADDR.
//
// Ports:
//   CLK_IN    system clock, rising edge
//   RST_N     asynchronous active-low reset
//   SCL_IN    bus SCL (asynchronous)
//   SDA_IN    bus SDA (asynchronous)
//   SDA_OE    1 = pull SDA low via external open-drain pad
//   RX_READY  consumer can accept a byte, sampled at each data ACK decision
//   RX_DATA   last accepted byte, held until the next accepted byte
//   RX_VALID  one-cycle pulse when RX_DATA updates
//   ADDR_HIT  one-cycle pulse on address match with R/W=0
//   STOP_DET  one-cycle pulse on STOP while BUSY
//   BUSY      high from address match until STOP or a missing repeated START

module i2c_target_rx #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    input  logic       RX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       ADDR_HIT,
    output logic       STOP_DET,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_WAIT_STOP
    } state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;

    // Synchronizers and one-sample history; all reset to 1 (idle bus).
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= SCL_IN;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= SDA_IN;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // START/STOP need SCL high in both samples, so an SDA change that lands
    // in the same sample as an SCL edge is treated as an ordinary data change.
    logic scl_high_stable;
    logic start_evt, stop_evt, scl_rise, scl_fall;

    assign scl_high_stable = scl_s2 & scl_d;
    assign start_evt       = scl_high_stable & sda_d & ~sda_s2;
    assign stop_evt        = scl_high_stable & ~sda_d & sda_s2;
    assign scl_rise        = scl_s2 & ~scl_d;
    assign scl_fall        = ~scl_s2 & scl_d;

    // Address byte decode: own address with write direction, optionally
    // the general-call byte.
    logic gencall_hit;
    logic addr_match;

`ifdef I2C_RX_GENCALL_EN
    assign gencall_hit = (shreg == 8'h00);
`else
    assign gencall_hit = 1'b0;
`endif

    assign addr_match = ((shreg[7:1] == ADDR) && !shreg[0]) || gencall_hit;

    // The 8th bit has been shifted in and SCL has just dropped: this is the
    // moment to drive (or withhold) the ACK for the following 9th clock.
    logic byte_done;
    assign byte_done = scl_fall && (bit_cnt == 4'd8);

    // Shift one bit per SCL rise until eight bits are collected.
    logic shift_en;
    assign shift_en = scl_rise && (bit_cnt != 4'd8);

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            SDA_OE   <= 1'b0;
            RX_DATA  <= 8'h00;
            RX_VALID <= 1'b0;
            ADDR_HIT <= 1'b0;
            STOP_DET <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            ADDR_HIT <= 1'b0;
            STOP_DET <= 1'b0;

            if (stop_evt) begin
                state    <= ST_IDLE;
                bit_cnt  <= 4'd0;
                SDA_OE   <= 1'b0;
                BUSY     <= 1'b0;
                STOP_DET <= BUSY;
            end else if (start_evt) begin
                // Also the repeated-START path: BUSY is kept until the new
                // address byte decides whether we are still addressed.
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                SDA_OE  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        SDA_OE <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (shift_en) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt <= 4'd0;
                            if (addr_match) begin
                                SDA_OE   <= 1'b1;
                                ADDR_HIT <= 1'b1;
                                BUSY     <= 1'b1;
                                state    <= ST_ADDR_ACK;
                            end else begin
                                SDA_OE <= 1'b0;
                                BUSY   <= 1'b0;
                                state  <= ST_WAIT_STOP;
                            end
                        end
                    end

                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        // ACK is held through the whole 9th clock and released
                        // on its falling edge.
                        if (scl_fall) begin
                            SDA_OE  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= ST_DATA;
                        end
                    end

                    ST_DATA: begin
                        if (shift_en) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt <= 4'd0;
                            if (RX_READY) begin
                                RX_DATA  <= shreg;
                                RX_VALID <= 1'b1;
                                SDA_OE   <= 1'b1;
                                state    <= ST_DATA_ACK;
                            end else begin
                                SDA_OE <= 1'b0;
                                state  <= ST_WAIT_STOP;
                            end
                        end
                    end

                    ST_WAIT_STOP: begin
                        SDA_OE <= 1'b0;
                    end

                    default: begin
                        state  <= ST_IDLE;
                        SDA_OE <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - self-checking bench for i2c_target_rx

module tb_i2c_target_rx;

    localparam int Q = 60;  // quarter SCL period in ns (CLK_IN period 10 ns)
    localparam logic [6:0] MY_ADDR = 7'h42;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, addr_hit, stop_det, busy;
    logic       bus_sda;

    assign bus_sda = m_sda & ~sda_oe;

    i2c_target_rx #(.ADDR(MY_ADDR)) dut (
        .CLK_IN  (clk),
        .RST_N   (rst_n),
        .SCL_IN  (m_scl),
        .SDA_IN  (bus_sda),
        .SDA_OE  (sda_oe),
        .RX_READY(rx_ready),
        .RX_DATA (rx_data),
        .RX_VALID(rx_valid),
        .ADDR_HIT(addr_hit),
        .STOP_DET(stop_det),
        .BUSY    (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Event monitor (sole writer of these), sampled on the falling edge.
    int         hit_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (addr_hit) hit_cnt++;
        if (stop_det) stop_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus master ----------------
    task automatic m_start();
        if (!m_scl) begin
            m_sda = 1'b1; #Q;
            m_scl = 1'b1; #Q;
        end
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic m_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #(2*Q);
    endtask

    task automatic m_bit(input logic b, output logic sampled);
        m_sda = b; #Q;
        m_scl = 1'b1; #Q;
        sampled = bus_sda;
        #Q;
        m_scl = 1'b0; #Q;
    endtask

    // Returns 1 when the target ACKed (SDA low on the 9th clock).
    task automatic m_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, s);
        ack = ~s;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_rx = 8'h00;

    function automatic logic model_addr_ack(input logic [6:0] a, input logic rw);
        logic gc;
`ifdef I2C_RX_GENCALL_EN
        gc = (a == 7'h00);
`else
        gc = 1'b0;
`endif
        return !rw && (a == MY_ADDR || gc);
    endfunction

    typedef struct packed {
        logic [6:0]  addr;
        logic        rw;
        logic [2:0]  n;
        logic [31:0] data;   // byte i at [31-8i -: 8]
        logic [3:0]  rdy;    // ready for byte i at bit i
    } vec_t;

    task automatic run_txn(input vec_t v);
        logic       ack, exp_ack, dead, exp_b;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        int         h0, s0, g0;
        h0 = hit_cnt; s0 = stop_cnt; g0 = got_q.size();
        exp_ack = model_addr_ack(v.addr, v.rw);
        m_start();
        m_byte({v.addr, v.rw}, ack);
        check("addr_ack", ack, exp_ack);
        check("busy_after_addr", busy, exp_ack);
        dead = !exp_ack;
        for (int i = 0; i < int'(v.n); i++) begin
            b = v.data[31-8*i -: 8];
            rx_ready = v.rdy[i];
            m_byte(b, ack);
            exp_b = !dead && v.rdy[i];
            if (exp_b) begin
                exp_q.push_back(b);
                exp_rx = b;
            end else begin
                dead = 1'b1;
            end
            check("data_ack", ack, exp_b);
        end
        check("rx_data_before_stop", rx_data, exp_rx);
        m_stop();
        rx_ready = 1'b1;
        #(2*Q);
        check("rx_count", got_q.size() - g0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (g0 + i < got_q.size()) check("rx_byte", got_q[g0+i], exp_q[i]);
        check("hit_count", hit_cnt - h0, exp_ack);
        check("stop_count", stop_cnt - s0, exp_ack);
        check("busy_after_stop", busy, 1'b0);
        check("oe_after_stop", sda_oe, 1'b0);
        check("rx_data_held", rx_data, exp_rx);
    endtask

    vec_t tbl[7];

    initial begin
        vec_t v;
        logic ack;
        logic s;
        int   r, g0, h0, s0;

        tbl[0] = '{addr: 7'h42, rw: 1'b0, n: 3'd1, data: 32'hA5000000, rdy: 4'b0001};
        tbl[1] = '{addr: 7'h43, rw: 1'b0, n: 3'd1, data: 32'h55000000, rdy: 4'b0001};
        tbl[2] = '{addr: 7'h42, rw: 1'b1, n: 3'd0, data: 32'h0,        rdy: 4'b0000};
        tbl[3] = '{addr: 7'h42, rw: 1'b0, n: 3'd2, data: 32'h01020000, rdy: 4'b0001};
        tbl[4] = '{addr: 7'h00, rw: 1'b0, n: 3'd1, data: 32'h7E000000, rdy: 4'b0001};
        tbl[5] = '{addr: 7'h42, rw: 1'b0, n: 3'd0, data: 32'h0,        rdy: 4'b0000};
        tbl[6] = '{addr: 7'h42, rw: 1'b0, n: 3'd3, data: 32'hFF00C300, rdy: 4'b0111};

        // Reset values
        #33;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_addr_hit", addr_hit, 1'b0);
        check("rst_stop_det", stop_det, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        #100;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
            #Q;
        end

        // Repeated START after three data bits, then a fresh write of 0x3C.
        g0 = got_q.size(); h0 = hit_cnt; s0 = stop_cnt;
        m_start();
        m_byte({MY_ADDR, 1'b0}, ack);
        check("rs_addr_ack1", ack, 1'b1);
        m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s);
        m_start();
        m_byte({MY_ADDR, 1'b0}, ack);
        check("rs_addr_ack2", ack, 1'b1);
        check("rs_busy", busy, 1'b1);
        m_byte(8'h3C, ack);
        check("rs_data_ack", ack, 1'b1);
        m_stop();
        #(2*Q);
        check("rs_rx_count", got_q.size() - g0, 1);
        if (got_q.size() > g0) check("rs_rx_byte", got_q[g0], 8'h3C);
        check("rs_hit_count", hit_cnt - h0, 2);
        check("rs_stop_count", stop_cnt - s0, 1);
        exp_rx = 8'h3C;
        #Q;

        // Reset while the address ACK is being driven.
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(i == 0 ? 1'b0 : MY_ADDR[i-1], s);
        m_sda = 1'b1;
        #(Q/2);
        check("ack_oe_before_rst", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", sda_oe, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_rx_data", rx_data, 8'h00);
        check("async_rst_rx_valid", rx_valid, 1'b0);
        check("async_rst_addr_hit", addr_hit, 1'b0);
        check("async_rst_stop_det", stop_det, 1'b0);
        #(Q/2 - 1);
        m_scl = 1'b1;
        #Q;
        rst_n = 1'b1;
        exp_rx = 8'h00;
        #(2*Q);
        v = '{addr: 7'h42, rw: 1'b0, n: 3'd1, data: 32'h5A000000, rdy: 4'b0001};
        run_txn(v);
        #Q;

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(0, 3);
            v.addr = (r < 2) ? MY_ADDR : (r == 2) ? 7'h00 : 7'($urandom);
            v.rw   = ($urandom_range(0, 4) == 0);
            v.n    = 3'($urandom_range(0, 3));
            v.data = $urandom;
            for (int k = 0; k < 4; k++) v.rdy[k] = ($urandom_range(0, 3) != 0);
            run_txn(v);
            #Q;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
